// File: rtl/counter_updown_mod_if.sv
// ============================================================================
// Module   : counter_updown_mod_if
// Purpose  : Bundles the control inputs and status outputs of
//            counter_updown_mod. The master side drives the controls and the
//            slave side (the counter) drives the status.
// Ports    : en_i       count enable
//            up_dn_i    direction, 1 = up, 0 = down
//            load_i     synchronous parallel load strobe
//            load_val_i value applied on load
//            count_o    registered count
//            tc_o       terminal count (combinational)
//            wrap_o     registered one-cycle wrap pulse
//            sat_o      registered saturation flag
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_updown_mod_if #(
  parameter int WIDTH = 3
);
  logic             en_i;
  logic             up_dn_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             tc_o;
  logic             wrap_o;
  logic             sat_o;

  modport master (
    output en_i, up_dn_i, load_i, load_val_i,
    input  count_o, tc_o, wrap_o, sat_o
  );

  modport slave (
    input  en_i, up_dn_i, load_i, load_val_i,
    output count_o, tc_o, wrap_o, sat_o
  );
endinterface

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// ============================================================================
// Module   : counter_updown_mod
// Purpose  : Synchronous up/down modulo counter with enable, parallel load,
//            programmable modulus, terminal-count and wrap flags.
//            Priority per posedge: load > enable > hold.
// Params   : WIDTH   count width in bits (>= 1)
//            MODULO  count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
// Ports    : clk     clock, all state changes on posedge
//            rst_n   asynchronous active-low reset
//            bus     counter_updown_mod_if.slave (controls in, status out)
// Config   : COUNTER_SAT_EN  when defined, the counter saturates at the
//            boundaries instead of wrapping and drives sat_o; when undefined
//            it wraps and sat_o is tied low.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_updown_mod #(
  parameter int WIDTH  = 3,
  parameter int MODULO = (1 << WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  counter_updown_mod_if.slave         bus
);

  // Highest legal count, sized to the counter width.
  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_load_clamped;

  // The next enabled step would leave 0..MODULO-1 in the current direction.
  assign w_at_bound = bus.up_dn_i ? (count_q == C_MAX) : (count_q == C_ZERO);

  // Out-of-range load values clamp to the top of the range so no illegal
  // state can ever be entered.
  assign w_load_clamped = (bus.load_val_i > C_MAX) ? C_MAX : bus.load_val_i;

`ifdef COUNTER_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (bus.load_i) begin
      count_d = w_load_clamped;
      sat_d   = 1'b0;
    end else if (bus.en_i) begin
      if (w_at_bound) begin
        // Hold at the boundary and flag saturation; never wrap.
        sat_d = 1'b1;
      end else begin
        count_d = bus.up_dn_i ? (count_q + C_ONE) : (count_q - C_ONE);
        sat_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.sat_o = sat_q;
`else
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load_i) begin
      count_d = w_load_clamped;
    end else if (bus.en_i) begin
      if (w_at_bound) begin
        // Wrap to the opposite end of the range; MODULO need not be a
        // power of two, so the natural binary rollover cannot be used.
        count_d = bus.up_dn_i ? C_ZERO : C_MAX;
        wrap_d  = 1'b1;
      end else begin
        count_d = bus.up_dn_i ? (count_q + C_ONE) : (count_q - C_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.sat_o = 1'b0;
`endif

  assign bus.count_o = count_q;
  assign bus.wrap_o  = wrap_q;
  // High in the cycle whose posedge will cross the boundary.
  assign bus.tc_o    = bus.en_i & ~bus.load_i & w_at_bound;

endmodule

`default_nettype wire
